// File: rtl/urv_periph_pkg.sv
// ----------------------------------------------------------------------------
// urv_periph_pkg
// Definitions shared by the data-bus peripherals: register indices, CTRL bit
// positions, the bus request payload and a CTRL read-word helper for the timer.
// ----------------------------------------------------------------------------
package urv_periph_pkg;

    // Bus geometry
    localparam int unsigned BUS_DATA_W  = 32;
    localparam int unsigned TMR_ADDR_W  = 2;

    // Upper address bits that select the timer window in the top-level decoder
    localparam logic [15:0] TMR_BASE_HI = 16'h1002;

    // Timer register indices (bus address bits [3:2])
    localparam logic [TMR_ADDR_W-1:0] TMR_CTRL     = 2'd0;
    localparam logic [TMR_ADDR_W-1:0] TMR_PRESCALE = 2'd1;
    localparam logic [TMR_ADDR_W-1:0] TMR_COUNT    = 2'd2;
    localparam logic [TMR_ADDR_W-1:0] TMR_COMPARE  = 2'd3;

    // CTRL bit positions
    localparam int unsigned EN_BIT = 0;
    localparam int unsigned AR_BIT = 1;
    localparam int unsigned IE_BIT = 2;
    localparam int unsigned MF_BIT = 8;

    // Slave-side view of one bus access
    typedef struct packed {
        logic                  sel;
        logic                  we;
        logic [TMR_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } tmr_req_t;

    // Writable CTRL fields
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } tmr_ctrl_t;

    // Assemble the CTRL read word; unimplemented bits read as zero
    function automatic logic [BUS_DATA_W-1:0] tmr_ctrl_word(input tmr_ctrl_t c,
                                                            input logic      mf);
        logic [BUS_DATA_W-1:0] w;
        w         = '0;
        w[EN_BIT] = c.en;
        w[AR_BIT] = c.auto_reload;
        w[IE_BIT] = c.irq_en;
        w[MF_BIT] = mf;
        return w;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// ----------------------------------------------------------------------------
// timer_prescaler
// Divides the system clock by (div + 1) and emits a one-cycle tick.
//   clk_i  in   system clock
//   rst_i  in   asynchronous active-low reset
//   en     in   count enable; the internal counter holds 0 while low
//   div    in   divide value; tick fires when the counter equals div
//   clr    in   restart the division from 0 (register write in the parent)
//   tick   out  high for the cycle in which the counter equals div
// ----------------------------------------------------------------------------
module timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    // Tick is decoded from the current count so the counter edge that wraps
    // to 0 is the same edge at which the parent consumes the tick.
    assign tick = en && (pre_cnt == div);

    // Prescale counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_cnt <= '0;
        end else if (clr || !en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/simple_timer.sv
// ----------------------------------------------------------------------------
// simple_timer
// Memory-mapped 32-bit timer/compare slave with prescaler, optional
// auto-reload and a level compare-match interrupt.
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-low reset
//   sel_i   in   slave select from the address decoder
//   addr_i  in   word index: 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE
//   we_i    in   write strobe (qualified by sel_i)
//   data_i  in   write data
//   data_o  out  registered read data, valid the cycle after a read access
//   irq_o   out  level interrupt, match_flag && irq_en
// ----------------------------------------------------------------------------
module simple_timer
    import urv_periph_pkg::*;
#(
    parameter int unsigned PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic [1:0]  addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    tmr_req_t              req;
    tmr_ctrl_t             ctrl;
    logic                  match_flag;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           count;
    logic [31:0]           compare;

    logic                  wr_c;
    logic                  rd_c;
    logic                  wr_ctrl_c;
    logic                  wr_pre_c;
    logic                  wr_count_c;
    logic                  wr_cmp_c;
    logic                  tick;
    logic                  match_c;
    logic                  flag_nxt_c;
    logic [31:0]           count_nxt_c;
    logic [31:0]           rdata_c;

    // Bundle the bus access
    assign req = '{sel: sel_i, we: we_i, addr: addr_i, wdata: data_i};

    // Access decode
    assign wr_c       = req.sel && req.we;
    assign rd_c       = req.sel && !req.we;
    assign wr_ctrl_c  = wr_c && (req.addr == TMR_CTRL);
    assign wr_pre_c   = wr_c && (req.addr == TMR_PRESCALE);
    assign wr_count_c = wr_c && (req.addr == TMR_COUNT);
    assign wr_cmp_c   = wr_c && (req.addr == TMR_COMPARE);

    // Prescaler restarts on any CTRL or PRESCALE write
    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ctrl.en),
        .div   (prescale),
        .clr   (wr_ctrl_c || wr_pre_c),
        .tick  (tick)
    );

    // Counter next value; a bus write to COUNT pre-empts the tick entirely,
    // including the match evaluation.
    always_comb begin
        count_nxt_c = count;
        match_c     = 1'b0;
        if (wr_count_c) begin
            count_nxt_c = req.wdata;
        end else if (tick) begin
            if (count == compare) begin
                match_c     = 1'b1;
                count_nxt_c = ctrl.auto_reload ? 32'd0 : count + 32'd1;
            end else begin
                count_nxt_c = count + 32'd1;
            end
        end
    end

    // Match flag: a new match beats a same-cycle write-1-to-clear
    always_comb begin
        flag_nxt_c = match_flag;
        if (match_c) begin
            flag_nxt_c = 1'b1;
        end else if (wr_ctrl_c && req.wdata[MF_BIT]) begin
            flag_nxt_c = 1'b0;
        end
    end

    // Register file
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl       <= '0;
            prescale   <= '0;
            count      <= '0;
            compare    <= RESET_COMPARE;
            match_flag <= 1'b0;
        end else begin
            if (wr_ctrl_c) begin
                ctrl <= '{irq_en:      req.wdata[IE_BIT],
                          auto_reload: req.wdata[AR_BIT],
                          en:          req.wdata[EN_BIT]};
            end
            if (wr_pre_c) begin
                prescale <= req.wdata[PRESCALE_W-1:0];
            end
            if (wr_cmp_c) begin
                compare <= req.wdata;
            end
            count      <= count_nxt_c;
            match_flag <= flag_nxt_c;
        end
    end

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (req.addr)
            TMR_CTRL:     rdata_c = tmr_ctrl_word(ctrl, match_flag);
            TMR_PRESCALE: rdata_c = 32'(prescale);
            TMR_COUNT:    rdata_c = count;
            TMR_COMPARE:  rdata_c = compare;
            default:      rdata_c = '0;
        endcase
    end

    // Read data register; holds while not read
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
        end else if (rd_c) begin
            data_o <= rdata_c;
        end
    end

    // Level interrupt straight from the flag so it follows the match edge
    assign irq_o = match_flag && ctrl.irq_en;

endmodule

// File: tb/tb_simple_timer.sv
// ----------------------------------------------------------------------------
// tb_simple_timer
// Self-checking bench for simple_timer: a register table, hand-written timing
// sequences and a randomized run against a behavioural model.
// ----------------------------------------------------------------------------
module tb_simple_timer;
    import urv_periph_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_chk;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    simple_timer #(
        .PRESCALE_W    (16),
        .RESET_COMPARE (32'hFFFF_FFFF)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .sel_i  (sel),
        .addr_i (addr),
        .we_i   (we),
        .data_i (wdata),
        .data_o (rdata),
        .irq_o  (irq)
    );

    // Behavioural model: m_age is the number of enabled cycles since the
    // prescaler was last restarted; a tick happens every (PRESCALE+1)-th one.
    logic        m_en, m_ar, m_ie, m_flag;
    logic [15:0] m_pres;
    logic [31:0] m_count, m_cmp, m_rdata;
    int unsigned m_age;

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0;
        m_pres = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF; m_rdata = '0;
        m_age = 0;
    endtask

    function automatic logic [31:0] model_view(input logic [1:0] a);
        case (a)
            2'd0:    return {23'd0, m_flag, 5'd0, m_ie, m_ar, m_en};
            2'd1:    return {16'd0, m_pres};
            2'd2:    return m_count;
            default: return m_cmp;
        endcase
    endfunction

    task automatic model_step(input logic s, input logic w, input logic [1:0] a,
                              input logic [31:0] d);
        logic wr, tck, hit;
        logic [31:0] nc;
        wr  = s && w;
        tck = m_en && ((m_age % (int'(m_pres) + 1)) == int'(m_pres));
        hit = 0;
        nc  = m_count;
        if (s && !w) m_rdata = model_view(a);
        if (wr && a == 2'd2) nc = d;
        else if (tck) begin
            if (m_count == m_cmp) begin
                hit = 1;
                nc  = m_ar ? 32'd0 : m_count + 32'd1;
            end else begin
                nc = m_count + 32'd1;
            end
        end
        if ((wr && (a == 2'd0 || a == 2'd1)) || !m_en) m_age = 0;
        else m_age = m_age + 1;
        if (hit) m_flag = 1;
        else if (wr && a == 2'd0 && d[8]) m_flag = 0;
        if (wr && a == 2'd0) begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
        if (wr && a == 2'd1) m_pres = d[15:0];
        if (wr && a == 2'd3) m_cmp = d;
        m_count = nc;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, advance the model, clock, then check against it
    task automatic cycle(input logic s, input logic w, input logic [1:0] a,
                         input logic [31:0] d);
        sel = s; we = w; addr = a; wdata = d;
        model_step(s, w, a, d);
        @(posedge clk);
        #1;
        chk("model_irq", 32'(irq), 32'(m_flag & m_ie));
        chk("model_data", rdata, m_rdata);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    typedef struct packed {
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic w, input logic [1:0] a,
                                input logic [31:0] d, input logic c,
                                input logic [31:0] e, input logic i);
        vec_t v;
        v.sel = s; v.we = w; v.addr = a; v.wdata = d;
        v.chk_data = c; v.exp_data = e; v.exp_irq = i;
        return v;
    endfunction

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    initial begin
        n_chk = 0;
        n_err = 0;
        sel = 0; we = 0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_irq", 32'(irq), 32'd0);
        chk("init_data", rdata, 32'd0);

        // Register access table (counter disabled, so timing is static)
        vecs[0]  = mk(1, 1, TMR_PRESCALE, 32'hFFFF_ABCD, 0, 32'd0,         0);
        vecs[1]  = mk(1, 0, TMR_PRESCALE, 32'd0,         1, 32'h0000_ABCD, 0);
        vecs[2]  = mk(1, 1, TMR_COUNT,    32'hDEAD_BEEF, 0, 32'd0,         0);
        vecs[3]  = mk(1, 0, TMR_COUNT,    32'd0,         1, 32'hDEAD_BEEF, 0);
        vecs[4]  = mk(1, 1, TMR_COMPARE,  32'h1234_5678, 0, 32'd0,         0);
        vecs[5]  = mk(1, 0, TMR_COMPARE,  32'd0,         1, 32'h1234_5678, 0);
        vecs[6]  = mk(1, 1, TMR_CTRL,     32'hFFFF_FEF6, 0, 32'd0,         0);
        vecs[7]  = mk(1, 0, TMR_CTRL,     32'd0,         1, 32'h0000_0006, 0);
        vecs[8]  = mk(0, 1, TMR_COUNT,    32'd0,         1, 32'h0000_0006, 0);
        vecs[9]  = mk(1, 0, TMR_COUNT,    32'd0,         1, 32'hDEAD_BEEF, 0);
        vecs[10] = mk(0, 0, TMR_COMPARE,  32'd0,         1, 32'hDEAD_BEEF, 0);
        vecs[11] = mk(1, 1, TMR_CTRL,     32'd0,         0, 32'd0,         0);
        vecs[12] = mk(1, 0, TMR_CTRL,     32'd0,         1, 32'd0,         0);
        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
        end

        // Prescale 0, no reload: irq 6 cycles after the enabling write
        wr_reg(TMR_CTRL, 32'h100); wr_reg(TMR_PRESCALE, 0);
        wr_reg(TMR_COUNT, 0);      wr_reg(TMR_COMPARE, 5);
        wr_reg(TMR_CTRL, 32'h5);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk($sformatf("p0_irq_k%0d", k), 32'(irq), 32'(k == 6));
        end
        rd_reg(TMR_COUNT); chk("p0_count_past", rdata, 32'd6);
        rd_reg(TMR_CTRL);  chk("p0_flag_held", rdata, 32'h105);
        rd_reg(TMR_COUNT); chk("p0_count_inc", rdata, 32'd8);

        // Match and W1C in the same cycle, then W1C alone
        wr_reg(TMR_CTRL, 32'h100); wr_reg(TMR_COUNT, 0);
        wr_reg(TMR_CTRL, 32'h5);
        repeat (5) idle();
        wr_reg(TMR_CTRL, 32'h107); chk("sim_set_wins_irq", 32'(irq), 32'd1);
        wr_reg(TMR_CTRL, 32'h107); chk("w1c_irq", 32'(irq), 32'd0);
        rd_reg(TMR_CTRL);          chk("w1c_ctrl", rdata, 32'h7);

        // Auto-reload: tick every 4 cycles, match every 40
        wr_reg(TMR_CTRL, 32'h100); wr_reg(TMR_COUNT, 0);
        wr_reg(TMR_PRESCALE, 3);   wr_reg(TMR_COMPARE, 9);
        wr_reg(TMR_CTRL, 32'h7);
        for (int k = 1; k <= 85; k++) begin
            rd_reg(TMR_COUNT);
            chk($sformatf("ar_count_k%0d", k), rdata, 32'(((k - 1) / 4) % 10));
            chk($sformatf("ar_irq_k%0d", k), 32'(irq), 32'(k >= 40));
        end

        // COUNT write on a tick cycle wins over the increment
        wr_reg(TMR_CTRL, 32'h100);     wr_reg(TMR_PRESCALE, 3);
        wr_reg(TMR_COMPARE, 32'hFFFF_0000); wr_reg(TMR_COUNT, 0);
        wr_reg(TMR_CTRL, 32'h1);
        repeat (3) idle();
        wr_reg(TMR_COUNT, 32'h1234);
        rd_reg(TMR_COUNT); chk("wt_write_wins", rdata, 32'h1234);
        idle(); idle();
        rd_reg(TMR_COUNT); chk("wt_before_tick", rdata, 32'h1234);
        rd_reg(TMR_COUNT); chk("wt_after_tick", rdata, 32'h1235);

        // Wrap from FFFF_FFFF without a flag, then match at 7
        wr_reg(TMR_CTRL, 32'h100); wr_reg(TMR_PRESCALE, 0);
        wr_reg(TMR_COMPARE, 7);    wr_reg(TMR_COUNT, 32'hFFFF_FFFF);
        wr_reg(TMR_CTRL, 32'h5);
        for (int k = 1; k <= 12; k++) begin
            rd_reg(TMR_COUNT);
            chk($sformatf("wrap_count_k%0d", k), rdata, 32'(k - 2));
            chk($sformatf("wrap_irq_k%0d", k), 32'(irq), 32'(k >= 9));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            d = $urandom;
            if (r < 55) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d);
            end else if (r < 78) begin
                rd_reg(2'($urandom_range(0, 3)));
            end else if (r < 85) begin
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                wr_reg(TMR_CTRL, d);
            end else if (r < 89) begin
                d[15:0] = 16'($urandom_range(0, 3));
                wr_reg(TMR_PRESCALE, d);
            end else if (r < 95) begin
                if ($urandom_range(0, 1) != 0) d = 32'($urandom_range(0, 15));
                else d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                wr_reg(TMR_COUNT, d);
            end else begin
                wr_reg(TMR_COMPARE, 32'($urandom_range(0, 15)));
            end
        end

        // Reset in the middle of counting
        wr_reg(TMR_PRESCALE, 0); wr_reg(TMR_COMPARE, 3);
        wr_reg(TMR_COUNT, 0);    wr_reg(TMR_CTRL, 32'h7);
        repeat (6) idle();
        rd_reg(TMR_COUNT);
        sel = 0; we = 0;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_data", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(TMR_CTRL);     chk("rst_ctrl", rdata, 32'd0);
        rd_reg(TMR_PRESCALE); chk("rst_prescale", rdata, 32'd0);
        rd_reg(TMR_COUNT);    chk("rst_count", rdata, 32'd0);
        rd_reg(TMR_COMPARE);  chk("rst_compare", rdata, 32'hFFFF_FFFF);
        repeat (3) idle();
        rd_reg(TMR_COUNT);    chk("rst_no_residual", rdata, 32'd0);
        chk("rst_irq_after", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
